tmr_scrub_counter: RTL and testbench

TMR_SCRUB_COUNTER -- requirements
Module: tmr_scrub_counter

---
 rtl/tmr_pkg.sv | 10 +
 rtl/tmr_voter.sv | 19 +
 rtl/tmr_scrub_counter.sv | 91 +++++++++
 tb/tb_tmr_scrub_counter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared defaults and constants for the triple-modular-redundant scrub counter.
package tmr_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_ERR_W = 8;

  // inj_sel code that selects no replica
  localparam logic [1:0] INJ_NONE = 2'd3;

endpackage : tmr_pkg

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority vote over three replicas, with per-replica disagreement flags.
module tmr_voter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] voted,
  output logic [2:0]       fault_vec,
  output logic             uncorrectable
);

  always_comb begin
    voted         = (r0 & r1) | (r1 & r2) | (r0 & r2);
    fault_vec     = {(r2 != voted), (r1 != voted), (r0 != voted)};
    uncorrectable = (r0 != r1) && (r1 != r2) && (r0 != r2);
  end

endmodule : tmr_voter

// File: rtl/tmr_scrub_counter.sv
// Up/down modulo counter held in three replicas that are rewritten from the vote every cycle,
// so a single-replica upset is scrubbed at the next edge.
module tmr_scrub_counter
  import tmr_pkg::*;
#(
  parameter int unsigned     WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int unsigned     ERR_W   = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inj_en,
  input  logic [1:0]       inj_sel,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q_out,
  output logic             tc,
  output logic [2:0]       fault_vec,
  output logic             uncorrectable,
  output logic [ERR_W-1:0] err_count
);

  logic [WIDTH-1:0] r0, r1, r2;
  logic [WIDTH-1:0] voted;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] m0, m1, m2;
  logic             inj_on;

  tmr_voter #(.WIDTH(WIDTH)) u_voter (
    .r0            (r0),
    .r1            (r1),
    .r2            (r2),
    .voted         (voted),
    .fault_vec     (fault_vec),
    .uncorrectable (uncorrectable)
  );

  // Next value is derived from the vote only, never from a single replica.
  always_comb begin
    nxt = voted;
    if (load) begin
      nxt = load_val;
    end else if (enable && up_down) begin
      nxt = (voted >= MAX_VAL) ? '0 : voted + WIDTH'(1);
    end else if (enable) begin
      nxt = (voted == '0) ? MAX_VAL : voted - WIDTH'(1);
    end
  end

  always_comb begin
    inj_on = inj_en && (inj_sel != INJ_NONE);
    m0     = (inj_on && (inj_sel == 2'd0)) ? inj_mask : '0;
    m1     = (inj_on && (inj_sel == 2'd1)) ? inj_mask : '0;
    m2     = (inj_on && (inj_sel == 2'd2)) ? inj_mask : '0;
  end

  always_comb begin
    q_out = voted;
    tc    = enable && !load &&
            ((up_down && (voted == MAX_VAL)) || (!up_down && (voted == '0)));
  end

  // Continuous scrub: every replica is rewritten each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      r0 <= nxt ^ m0;
      r1 <= nxt ^ m1;
      r2 <= nxt ^ m2;
    end
  end

  // Saturating count of cycles with any replica out of agreement; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if ((|fault_vec) && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule : tmr_scrub_counter

// File: tb/tb_tmr_scrub_counter.sv
// Self-checking bench: a 16-bit default instance and a 4-bit mod-10 instance with a 2-bit error
// counter share stimulus and are each compared against a value-level model.
module tb_tmr_scrub_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, up_down, load, inj_en, err_clr;
  logic [1:0]  inj_sel;
  logic [15:0] load_val, inj_mask;
  logic [3:0]  load_val_b, inj_mask_b;

  logic [15:0] qa;
  logic        tca, unca;
  logic [2:0]  fva;
  logic [7:0]  erra;
  logic [3:0]  qb;
  logic        tcb, uncb;
  logic [2:0]  fvb;
  logic [1:0]  errb;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: true count, index of the single upset replica (-1 none), error count
  longint ma_cnt, ma_err, mb_cnt, mb_err;
  int     ma_sel, mb_sel;

  assign load_val_b = load_val[3:0];
  assign inj_mask_b = inj_mask[3:0];

  always #5 clk = ~clk;

  tmr_scrub_counter dut_a (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
    .load_val(load_val), .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
    .err_clr(err_clr), .q_out(qa), .tc(tca), .fault_vec(fva),
    .uncorrectable(unca), .err_count(erra)
  );

  tmr_scrub_counter #(.WIDTH(4), .MAX_VAL(4'd9), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
    .load_val(load_val_b), .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask_b),
    .err_clr(err_clr), .q_out(qb), .tc(tcb), .fault_vec(fvb),
    .uncorrectable(uncb), .err_count(errb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input longint maxv, input longint wmask, input longint emax,
                            inout longint cnt, inout int psel, inout longint err);
    longint lv, im;
    lv = longint'(load_val) & wmask;
    im = longint'(inj_mask) & wmask;
    if (rst) begin
      cnt = 0; psel = -1; err = 0;
    end else begin
      if (err_clr) err = 0;
      else if (psel >= 0 && err < emax) err = err + 1;
      if (load) cnt = lv;
      else if (enable && up_down) cnt = (cnt >= maxv) ? 0 : cnt + 1;
      else if (enable) cnt = (cnt == 0) ? maxv : cnt - 1;
      psel = (inj_en && inj_sel != 2'd3 && im != 0) ? int'(inj_sel) : -1;
    end
  endtask

  function automatic logic exp_tc(input longint cnt, input longint maxv);
    return enable && !load && ((up_down && cnt == maxv) || (!up_down && cnt == 0));
  endfunction

  function automatic logic [2:0] exp_fv(input int psel);
    return (psel >= 0) ? 3'(1 << psel) : 3'b000;
  endfunction

  task automatic model_reset();
    ma_cnt = 0; ma_sel = -1; ma_err = 0;
    mb_cnt = 0; mb_sel = -1; mb_err = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(64'hFFFF, 64'hFFFF, 255, ma_cnt, ma_sel, ma_err);
    model_step(9, 15, 3, mb_cnt, mb_sel, mb_err);
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic ud, input logic ld, input logic [15:0] lv,
                       input logic ie, input logic [1:0] is, input logic [15:0] im,
                       input logic ec);
    enable = en; up_down = ud; load = ld; load_val = lv;
    inj_en = ie; inj_sel = is; inj_mask = im; err_clr = ec;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".qa"},   64'(qa),   64'(ma_cnt));
    check({tag, ".tca"},  64'(tca),  64'(exp_tc(ma_cnt, 64'hFFFF)));
    check({tag, ".fva"},  64'(fva),  64'(exp_fv(ma_sel)));
    check({tag, ".unca"}, 64'(unca), 64'd0);
    check({tag, ".erra"}, 64'(erra), 64'(ma_err));
    check({tag, ".qb"},   64'(qb),   64'(mb_cnt));
    check({tag, ".tcb"},  64'(tcb),  64'(exp_tc(mb_cnt, 9)));
    check({tag, ".fvb"},  64'(fvb),  64'(exp_fv(mb_sel)));
    check({tag, ".uncb"}, 64'(uncb), 64'd0);
    check({tag, ".errb"}, 64'(errb), 64'(mb_err));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 16'h0, 0, 2'd3, 16'h0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    // tc during reset follows enable && !load && !up_down
    drive(1, 0, 0, 16'h0, 0, 2'd3, 16'h0, 0);
    #1 check("reset_tc_down", 64'(tca), 64'd1);
    tick();
    rst = 1'b0;

    // count up from zero
    drive(1, 1, 0, 16'h0, 0, 2'd3, 16'h0, 0);
    #1 check("up0", 64'(qa), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      #1 check($sformatf("up%0d", i), 64'(qa), 64'(i));
      check($sformatf("up%0d_fv", i), 64'(fva), 64'd0);
      check($sformatf("up%0d_err", i), 64'(erra), 64'd0);
    end

    // mod-10 wrap on the 4-bit instance
    drive(0, 0, 1, 16'h0009, 0, 2'd3, 16'h0, 0);
    tick();
    drive(1, 1, 0, 16'h0, 0, 2'd3, 16'h0, 0);
    #1 check("b_at9", 64'(qb), 64'd9);
    check("b_tc_up9", 64'(tcb), 64'd1);
    check_model("wrap_up_pre");
    tick();
    #1 check("b_wrap0", 64'(qb), 64'd0);
    drive(1, 0, 0, 16'h0, 0, 2'd3, 16'h0, 0);
    #1 check("b_tc_dn0", 64'(tcb), 64'd1);
    tick();
    #1 check("b_wrap9", 64'(qb), 64'd9);

    // single-bit upset in replica 1 is voted out and scrubbed
    drive(0, 0, 1, 16'h0010, 0, 2'd3, 16'h0, 0);
    tick();
    drive(0, 0, 0, 16'h0, 1, 2'd1, 16'h0001, 0);
    tick();
    drive(0, 0, 0, 16'h0, 0, 2'd3, 16'h0, 0);
    #1 check("inj_q", 64'(qa), 64'h10);
    check("inj_fv", 64'(fva), 64'b010);
    check("inj_unc", 64'(unca), 64'd0);
    check("inj_err0", 64'(erra), 64'd0);
    tick();
    #1 check("scrub_fv", 64'(fva), 64'd0);
    check("scrub_err", 64'(erra), 64'd1);

    // back-to-back upsets in different replicas
    drive(0, 0, 0, 16'h0, 0, 2'd3, 16'h0, 1);
    tick();
    drive(0, 0, 0, 16'h0, 1, 2'd0, 16'h0001, 0);
    tick();
    #1 check("seq_q1", 64'(qa), 64'h10);
    drive(0, 0, 0, 16'h0, 1, 2'd1, 16'h0002, 0);
    tick();
    #1 check("seq_q2", 64'(qa), 64'h10);
    drive(0, 0, 0, 16'h0, 0, 2'd3, 16'h0, 0);
    tick();
    #1 check("seq_q3", 64'(qa), 64'h10);
    check("seq_err2", 64'(erra), 64'd2);
    check_model("seq");

    // three-way divergence forced from outside: vote is still bitwise majority
    force dut_a.r0 = 16'h00FF;
    force dut_a.r1 = 16'h0F0F;
    force dut_a.r2 = 16'h3333;
    #1 check("div_unc", 64'(unca), 64'd1);
    check("div_q", 64'(qa), 64'h033F);
    check("div_fv", 64'(fva), 64'b111);
    rst = 1'b1;
    #1;
    release dut_a.r0;
    release dut_a.r1;
    release dut_a.r2;
    model_reset();
    tick();
    #1 check_model("div_reset");
    rst = 1'b0;

    // saturation of the 2-bit error counter, then clear beats a fault
    drive(0, 0, 0, 16'h0, 1, 2'd2, 16'h0001, 0);
    repeat (5) tick();
    drive(0, 0, 0, 16'h0, 0, 2'd3, 16'h0, 0);
    tick();
    #1 check("b_sat", 64'(errb), 64'd3);
    drive(0, 0, 0, 16'h0, 1, 2'd0, 16'h0001, 0);
    tick();
    drive(0, 0, 0, 16'h0, 0, 2'd3, 16'h0, 1);
    #1 check("b_clr_fault", 64'(fvb), 64'b001);
    tick();
    #1 check("b_clr", 64'(errb), 64'd0);
    check_model("clr");

    // load beats step
    drive(1, 1, 1, 16'h1234, 0, 2'd3, 16'h0, 0);
    #1 check("ld_tc", 64'(tca), 64'd0);
    tick();
    #1 check("ld_q", 64'(qa), 64'h1234);

    // reset in the middle of counting
    drive(0, 0, 1, 16'h0005, 0, 2'd3, 16'h0, 0);
    tick();
    drive(1, 1, 0, 16'h0, 0, 2'd3, 16'h0, 0);
    repeat (2) tick();
    #1 check("mid_q7", 64'(qa), 64'd7);
    rst = 1'b1;
    #1 check("mid_rst_q", 64'(qa), 64'd0);
    model_reset();
    tick();
    rst = 1'b0;
    #1 check_model("mid_rst");

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] lv;
      lv = ($urandom_range(3) == 0) ? 16'($urandom_range(11)) : 16'($urandom);
      drive(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom_range(7) == 0), lv,
            1'($urandom_range(2) == 0), 2'($urandom), 16'($urandom),
            1'($urandom_range(15) == 0));
      rst = 1'($urandom_range(63) == 0);
      if (rst) model_reset();
      #1 check_model("rand");
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tmr_scrub_counter
